loop_addr_gen: RTL and testbench
================================

# loop_addr_gen

Computes memory addresses from loop indices. It sits directly downstream of the group-aware loop-iteration controller. Each cycle it takes the controller's flattened per-loop iteration vector and active group id, and produces `addr = base[g] + Σ iter[l]·stride[g][l]` through a 2-stage pipeline with output backpressure. The block is the address front-end for the scratchpad/DRAM request ports.

## Interface
- `LOOP_ID_W`, 3: loop id width.
- `NUM_MAX_LOOPS`, 1<<LOOP_ID_W: number of loop levels.
- `GROUP_ID_W`, 2: group id width.
- `NUM_MAX_GROUPS`, 1<<GROUP_ID_W: number of stride/base table sets.
- `LOOP_ITER_W`, 16: iteration index width; must match the controller.
- `STRIDE_W`, 16: stride width.
- `ADDR_W`, 32: address width.
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-low. `reset==0` at a `clk` edge resets the block.
- `cfg_base_v` in 1: base write strobe.
- `cfg_base_addr` in ADDR_W: base value.
- `cfg_stride_v` in 1: stride write strobe.
- `cfg_stride` in STRIDE_W: stride value.
- `cfg_stride_loop_id` in LOOP_ID_W: target loop for the stride write.
- `cfg_group_id` in GROUP_ID_W: target group for either write.
- `block_done` in 1: clears all base/stride tables.
- `iter_v` in 1: `current_iters` is a new valid point.
- `current_iters` in LOOP_ITER_W*NUM_MAX_LOOPS: loop l occupies bits `[LOOP_ITER_W*l +: LOOP_ITER_W]`.
- `loop_group_id` in GROUP_ID_W: group of the current point.
- `iter_last` in 1: the current point is the final one of the block (the controller's `done`).
- `stall` out 1: backpressure to the controller; the controller holds its iterations while this is high.
- `addr_v` out 1: address valid.
- `addr` out ADDR_W: computed address.
- `addr_last` out 1: address belongs to the final point.
- `addr_ready` in 1: consumer accepts `addr` when `addr_v && addr_ready`.

## Operation
- Tables:
  - `base[g]`: ADDR_W bits.
  - `stride[g][l]`: STRIDE_W bits.
  - Both are written on their strobe at the `clk` edge. Writes with different targets can occur in the same cycle.
- `block_done` zeroes every base and stride entry. If a cfg strobe is asserted in the same cycle, the cfg write takes priority for the addressed entry.
- The table read for a point uses the contents present at its S1 sample cycle. A write in that same cycle is not visible to that point.
- Stage S1, on advance:
  - Register `prod[l] = iter[l]*stride[g][l]` (unsigned, LOOP_ITER_W+STRIDE_W bits).
  - Register `base[g]`, `iter_last`, and `s1_v = iter_v`.
- Stage S2, on advance:
  - Register the sum of all products plus base, truncated modulo 2^ADDR_W (wrap, no saturation or flag).
  - Register `addr_v = s1_v` and `addr_last`.
- Advance rule: `adv = ~(addr_v && ~addr_ready)`. All stages hold together when `adv` is 0.
- `stall = ~adv` (combinational from `addr_v` and `addr_ready`).
- When `iter_v` is high while `stall` is high, the point is not captured. The controller must present it again.
- States per stage are valid/empty only; there is no FSM beyond the valid bits.

## Timing
- Latency: `iter_v` sampled at edge N with `stall==0` → `addr_v` high after edge N+1. That is 2 registered stages.
- Throughput: 1 address/cycle while `addr_ready==1`.
- Reset (`reset==0`):
  - `addr_v=0`, `addr=0`, `addr_last=0`, `s1_v=0`, `stall=0`.
  - All tables cleared.
  - Reset mid-operation flushes in-flight points with no output.
- Held output: `addr` and `addr_last` stay stable while `addr_v && ~addr_ready`.
- Simultaneous events:
  - `block_done` together with `iter_v`: the point uses the pre-clear tables.
  - `iter_last` travels with its point, so `addr_last` pulses exactly once per block.

## Configuration
- Macro `LOOP_ADDR_GEN_SIGNED_STRIDE_EN`.
- Defined:
  - `cfg_stride` and the table entries are two's-complement.
  - Products are signed (iter zero-extended by 1 bit).
  - The sum is sign-extended before the modulo-2^ADDR_W truncation, which allows descending traversal.
- Undefined: strides are unsigned as described above.

## Structure
- Shared package/header `genesys_addr_pkg`:
  - Defaults for LOOP_ITER_W, STRIDE_W, ADDR_W.
  - The product-width constant.
  - The flattened-iteration slice helper.
  - The controller also uses these defaults.
- One sub-module: `addr_gen_adder_tree`. A combinational reduction of NUM_MAX_LOOPS products plus base, instantiated between S1 and S2.

## Test plan
- Group 0: base=0x1000, strides {1,16,256,0…}; iters {3,2,1} → addr=0x1123; `addr_v` two cycles after `iter_v`.
- Group switch: group 1 base=0x8000, stride[0]=4; alternate groups each cycle → addresses match per group, no bubbles.
- Backpressure: `addr_ready=0` for 3 cycles mid-stream → `stall` high for those cycles, `addr` held, no point lost or duplicated.
- Wrap: base=0xFFFF_FFF0, stride[0]=1, iter=0x20 → addr=0x0000_0010.
- `block_done` with a same-cycle stride write to g0 l0 = 8 → only that entry is 8, all others 0. `reset==0` mid-stream → `addr_v=0` next cycle, tables zero.
- With `LOOP_ADDR_GEN_SIGNED_STRIDE_EN`: base=0x100, stride[0]=-4 (0xFFFC), iter=3 → addr=0xF4.

Source files
------------

// File: rtl/genesys_addr_pkg.sv
`default_nettype none
//============================================================================
// Package  : genesys_addr_pkg
// Brief    : Shared widths and helpers for the loop controller and address generator.
// Config   : LOOP_ADDR_GEN_SIGNED_STRIDE_EN widens products by one sign bit
// Revision : 1.0
//============================================================================
package genesys_addr_pkg;

  localparam int c_loop_iter_w_def = 16;
  localparam int c_stride_w_def    = 16;
  localparam int c_addr_w_def      = 32;

  function automatic int prod_width(input int iter_w, input int stride_w);
`ifdef LOOP_ADDR_GEN_SIGNED_STRIDE_EN
    return iter_w + stride_w + 1;
`else
    return iter_w + stride_w;
`endif
  endfunction

  localparam int c_prod_w_def = prod_width(c_loop_iter_w_def, c_stride_w_def);

  // LSB of loop l inside the controller's flattened iteration vector
  function automatic int iter_lsb(input int loop_id, input int iter_w);
    return loop_id * iter_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addr_gen_adder_tree.sv
`default_nettype none
//============================================================================
// Module   : addr_gen_adder_tree
// Brief    : Combinational sum of NUM_IN products plus base, modulo 2^ADDR_W.
// Config   : LOOP_ADDR_GEN_SIGNED_STRIDE_EN sign-extends the products
// Revision : 1.0
//============================================================================
module addr_gen_adder_tree
  import genesys_addr_pkg::*;
#(
  parameter int NUM_IN = 8,
  parameter int PROD_W = c_prod_w_def,
  parameter int ADDR_W = c_addr_w_def
) (
  input  logic [NUM_IN*PROD_W-1:0] prods,
  input  logic [ADDR_W-1:0]        base,
  output logic [ADDR_W-1:0]        sum
);

  localparam int c_ext_w = (PROD_W > ADDR_W) ? PROD_W : ADDR_W;

  logic [c_ext_w-1:0] w_ext [NUM_IN];
  logic [c_ext_w-1:0] w_acc;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_ext
`ifdef LOOP_ADDR_GEN_SIGNED_STRIDE_EN
    assign w_ext[i] = c_ext_w'($signed(prods[i*PROD_W +: PROD_W]));
`else
    assign w_ext[i] = c_ext_w'(prods[i*PROD_W +: PROD_W]);
`endif
  end

  always_comb begin
    w_acc = c_ext_w'(base);
    for (int i = 0; i < NUM_IN; i++) begin
      w_acc = w_acc + w_ext[i];
    end
  end

  // Bits above ADDR_W are dropped: the address wraps silently
  if (c_ext_w > ADDR_W) begin : g_hi
    logic w_unused_hi;
    assign w_unused_hi = ^w_acc[c_ext_w-1:ADDR_W];
  end

  assign sum = w_acc[ADDR_W-1:0];

endmodule
`default_nettype wire

// File: rtl/loop_addr_gen.sv
`default_nettype none
//============================================================================
// Module   : loop_addr_gen
// Brief    : addr = base[g] + sum(iter[l]*stride[g][l]), 2-stage pipeline with backpressure.
// Config   : LOOP_ADDR_GEN_SIGNED_STRIDE_EN selects two's-complement strides
// Revision : 1.0
//============================================================================
module loop_addr_gen
  import genesys_addr_pkg::*;
#(
  parameter int LOOP_ID_W      = 3,
  parameter int NUM_MAX_LOOPS  = 1 << LOOP_ID_W,
  parameter int GROUP_ID_W     = 2,
  parameter int NUM_MAX_GROUPS = 1 << GROUP_ID_W,
  parameter int LOOP_ITER_W    = c_loop_iter_w_def,
  parameter int STRIDE_W       = c_stride_w_def,
  parameter int ADDR_W         = c_addr_w_def
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 cfg_base_v,
  input  logic [ADDR_W-1:0]                    cfg_base_addr,
  input  logic                                 cfg_stride_v,
  input  logic [STRIDE_W-1:0]                  cfg_stride,
  input  logic [LOOP_ID_W-1:0]                 cfg_stride_loop_id,
  input  logic [GROUP_ID_W-1:0]                cfg_group_id,
  input  logic                                 block_done,
  input  logic                                 iter_v,
  input  logic [LOOP_ITER_W*NUM_MAX_LOOPS-1:0] current_iters,
  input  logic [GROUP_ID_W-1:0]                loop_group_id,
  input  logic                                 iter_last,
  output logic                                 stall,
  output logic                                 addr_v,
  output logic [ADDR_W-1:0]                    addr,
  output logic                                 addr_last,
  input  logic                                 addr_ready
);

  localparam int c_prod_w = prod_width(LOOP_ITER_W, STRIDE_W);

  logic [ADDR_W-1:0]                 r_base   [NUM_MAX_GROUPS];
  logic [STRIDE_W-1:0]               r_stride [NUM_MAX_GROUPS][NUM_MAX_LOOPS];
  logic [c_prod_w-1:0]               w_prod   [NUM_MAX_LOOPS];
  logic [c_prod_w-1:0]               r_prod   [NUM_MAX_LOOPS];
  logic [NUM_MAX_LOOPS*c_prod_w-1:0] w_prod_flat;
  logic [ADDR_W-1:0]                 r_s1_base;
  logic [ADDR_W-1:0]                 w_sum;
  logic [ADDR_W-1:0]                 r_addr;
  logic                              r_s1_v;
  logic                              r_s1_last;
  logic                              r_addr_v;
  logic                              r_addr_last;
  logic                              w_adv;

  // Clear first so a same-cycle cfg write lands on top of block_done
  always_ff @(posedge clk) begin
    if (!reset || block_done) begin
      for (int g = 0; g < NUM_MAX_GROUPS; g++) begin
        r_base[g] <= '0;
        for (int l = 0; l < NUM_MAX_LOOPS; l++) begin
          r_stride[g][l] <= '0;
        end
      end
    end
    if (reset && cfg_base_v) begin
      r_base[cfg_group_id] <= cfg_base_addr;
    end
    if (reset && cfg_stride_v) begin
      r_stride[cfg_group_id][cfg_stride_loop_id] <= cfg_stride;
    end
  end

  for (genvar l = 0; l < NUM_MAX_LOOPS; l++) begin : g_loop
    logic [LOOP_ITER_W-1:0] w_iter;
    logic [STRIDE_W-1:0]    w_stride;

    assign w_iter   = current_iters[iter_lsb(l, LOOP_ITER_W) +: LOOP_ITER_W];
    assign w_stride = r_stride[loop_group_id][l];
`ifdef LOOP_ADDR_GEN_SIGNED_STRIDE_EN
    assign w_prod[l] = c_prod_w'($signed({1'b0, w_iter})) * c_prod_w'($signed(w_stride));
`else
    assign w_prod[l] = c_prod_w'(w_iter) * c_prod_w'(w_stride);
`endif
    assign w_prod_flat[l*c_prod_w +: c_prod_w] = r_prod[l];
  end

  addr_gen_adder_tree #(
    .NUM_IN (NUM_MAX_LOOPS),
    .PROD_W (c_prod_w),
    .ADDR_W (ADDR_W)
  ) u_adder_tree (
    .prods (w_prod_flat),
    .base  (r_s1_base),
    .sum   (w_sum)
  );

  assign w_adv = ~(r_addr_v & ~addr_ready);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1_v      <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_base   <= '0;
      for (int l = 0; l < NUM_MAX_LOOPS; l++) begin
        r_prod[l] <= '0;
      end
      r_addr_v    <= 1'b0;
      r_addr      <= '0;
      r_addr_last <= 1'b0;
    end else if (w_adv) begin
      r_s1_v      <= iter_v;
      r_s1_last   <= iter_v & iter_last;
      r_s1_base   <= r_base[loop_group_id];
      for (int l = 0; l < NUM_MAX_LOOPS; l++) begin
        r_prod[l] <= w_prod[l];
      end
      r_addr_v    <= r_s1_v;
      r_addr      <= w_sum;
      r_addr_last <= r_s1_last;
    end
  end

  assign stall     = ~w_adv;
  assign addr_v    = r_addr_v;
  assign addr      = r_addr;
  assign addr_last = r_addr_last;

endmodule
`default_nettype wire

// File: tb/tb_loop_addr_gen.sv
`default_nettype none
//============================================================================
// Module   : tb_loop_addr_gen
// Brief    : Scoreboard bench for loop_addr_gen (honours LOOP_ADDR_GEN_SIGNED_STRIDE_EN).
// Revision : 1.0
//============================================================================
module tb_loop_addr_gen;

  localparam int IW = 16 * 8;

  typedef struct {
    logic [31:0] a;
    logic        l;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_base_v = 1'b0;
  logic [31:0]   cfg_base_addr = '0;
  logic          cfg_stride_v = 1'b0;
  logic [15:0]   cfg_stride = '0;
  logic [2:0]    cfg_stride_loop_id = '0;
  logic [1:0]    cfg_group_id = '0;
  logic          block_done = 1'b0;
  logic          iter_v = 1'b0;
  logic [IW-1:0] current_iters = '0;
  logic [1:0]    loop_group_id = '0;
  logic          iter_last = 1'b0;
  logic          stall;
  logic          addr_v;
  logic [31:0]   addr;
  logic          addr_last;
  logic          addr_ready = 1'b1;

  logic [31:0] m_base [4];
  logic [15:0] m_stride [4][8];
  exp_t        q [$];

  logic        s_v, s_acc, s_last, s_stall;
  logic [31:0] s_addr;
  int          checks = 0;
  int          errors = 0;

  loop_addr_gen #(
    .LOOP_ID_W   (3),
    .GROUP_ID_W  (2),
    .LOOP_ITER_W (16),
    .STRIDE_W    (16),
    .ADDR_W      (32)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .cfg_base_v         (cfg_base_v),
    .cfg_base_addr      (cfg_base_addr),
    .cfg_stride_v       (cfg_stride_v),
    .cfg_stride         (cfg_stride),
    .cfg_stride_loop_id (cfg_stride_loop_id),
    .cfg_group_id       (cfg_group_id),
    .block_done         (block_done),
    .iter_v             (iter_v),
    .current_iters      (current_iters),
    .loop_group_id      (loop_group_id),
    .iter_last          (iter_last),
    .stall              (stall),
    .addr_v             (addr_v),
    .addr               (addr),
    .addr_last          (addr_last),
    .addr_ready         (addr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_addr(input logic [1:0] g, input logic [IW-1:0] it);
`ifdef LOOP_ADDR_GEN_SIGNED_STRIDE_EN
    longint acc;
    acc = longint'(m_base[g]);
    for (int l = 0; l < 8; l++) begin
      acc = acc + longint'(it[16*l +: 16]) * longint'($signed(m_stride[g][l]));
    end
`else
    longint unsigned acc;
    acc = longint'(m_base[g]);
    for (int l = 0; l < 8; l++) begin
      acc = acc + longint'(it[16*l +: 16]) * longint'(m_stride[g][l]);
    end
`endif
    return acc[31:0];
  endfunction

  function automatic logic [IW-1:0] pack3(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c);
    logic [IW-1:0] r;
    r = '0;
    r[15:0]  = a;
    r[31:16] = b;
    r[47:32] = c;
    return r;
  endfunction

  // One clock: drive inputs, sample outputs before the edge, update the model.
  task automatic step(input logic v, input logic [IW-1:0] it, input logic [1:0] g,
                      input logic last, input logic rdy);
    exp_t e;
    iter_v        = v;
    current_iters = it;
    loop_group_id = g;
    iter_last     = last;
    addr_ready    = rdy;
    #1;
    s_v     = addr_v;
    s_acc   = addr_v && addr_ready;
    s_addr  = addr;
    s_last  = addr_last;
    s_stall = stall;
    if (!reset) begin
      q.delete();
    end else if (v && !s_stall) begin
      e.a = model_addr(g, it);
      e.l = last;
      q.push_back(e);
    end
    if (!reset || block_done) begin
      for (int gg = 0; gg < 4; gg++) begin
        m_base[gg] = '0;
        for (int l = 0; l < 8; l++) m_stride[gg][l] = '0;
      end
    end
    if (reset && cfg_base_v) m_base[cfg_group_id] = cfg_base_addr;
    if (reset && cfg_stride_v) m_stride[cfg_group_id][cfg_stride_loop_id] = cfg_stride;
    @(negedge clk);
    cfg_base_v   = 1'b0;
    cfg_stride_v = 1'b0;
    block_done   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(1'b0, '0, 2'd0, 1'b0, 1'b1);
    step(1'b0, '0, 2'd0, 1'b0, 1'b1);
    checks += 4;
    if (s_v !== 1'b0) begin errors++; $display("FAIL reset_addr_v: got %b want 0", s_v); end
    if (s_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", s_addr); end
    if (s_last !== 1'b0) begin errors++; $display("FAIL reset_addr_last: got %b want 0", s_last); end
    if (s_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", s_stall); end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    exp_t e;
    int   n = 0;
    cfg_group_id = 2'd0;
    cfg_base_v = 1'b1; cfg_base_addr = 32'h1000;
    cfg_stride_v = 1'b1; cfg_stride_loop_id = 3'd0; cfg_stride = 16'd1;
    step(1'b0, '0, 2'd0, 1'b0, 1'b1);
    cfg_stride_v = 1'b1; cfg_stride_loop_id = 3'd1; cfg_stride = 16'd16;
    step(1'b0, '0, 2'd0, 1'b0, 1'b1);
    cfg_stride_v = 1'b1; cfg_stride_loop_id = 3'd2; cfg_stride = 16'd256;
    step(1'b0, '0, 2'd0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step(k == 0, pack3(16'd3, 16'd2, 16'd1), 2'd0, k == 0, 1'b1);
      if (s_acc) begin
        n++;
        checks += 3;
        if (k != 2) begin errors++; $display("FAIL basic_latency: output at step %0d want step 2", k); end
        if (s_addr !== 32'h1123) begin errors++; $display("FAIL basic_const: got %h want 00001123", s_addr); end
        if (q.size() == 0) begin
          errors++; $display("FAIL basic_out: unexpected addr %h", s_addr);
        end else begin
          e = q.pop_front();
          if (s_addr !== e.a || s_last !== e.l) begin
            errors++;
            $display("FAIL basic_out: got %h/%b want %h/%b", s_addr, s_last, e.a, e.l);
          end
        end
      end
    end
    checks++;
    if (n != 1) begin errors++; $display("FAIL basic_count: got %0d want 1", n); end
  endtask

  task automatic test_group_switch();
    exp_t e;
    int   n = 0;
    cfg_group_id = 2'd1;
    cfg_base_v = 1'b1; cfg_base_addr = 32'h8000;
    cfg_stride_v = 1'b1; cfg_stride_loop_id = 3'd0; cfg_stride = 16'd4;
    step(1'b0, '0, 2'd0, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      step(k < 8, {$urandom, $urandom, $urandom, $urandom}, 2'(k % 2), k == 7, 1'b1);
      checks++;
      if (s_acc !== (k >= 2 && k < 10)) begin
        errors++; $display("FAIL group_bubble: step %0d valid %b want %b", k, s_acc, (k >= 2 && k < 10));
      end
      if (s_acc) begin
        n++;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL group_out: unexpected addr %h", s_addr);
        end else begin
          e = q.pop_front();
          if (s_addr !== e.a || s_last !== e.l) begin
            errors++;
            $display("FAIL group_out: got %h/%b want %h/%b", s_addr, s_last, e.a, e.l);
          end
        end
      end
    end
    checks++;
    if (n != 8) begin errors++; $display("FAIL group_count: got %0d want 8", n); end
  endtask

  task automatic test_backpressure();
    exp_t          e;
    logic [IW-1:0] pts [10];
    int            idx = 0;
    int            n = 0;
    logic          rdy, v;
    for (int i = 0; i < 10; i++) pts[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 30; k++) begin
      rdy = !(k >= 4 && k <= 6);
      v   = idx < 10;
      step(v, v ? pts[idx] : '0, 2'd0, v && idx == 9, rdy);
      checks++;
      if (s_stall !== !rdy) begin
        errors++; $display("FAIL bp_stall: step %0d got %b want %b", k, s_stall, !rdy);
      end
      if (!rdy && q.size() > 0) begin
        checks++;
        if (s_v !== 1'b1 || s_addr !== q[0].a) begin
          errors++; $display("FAIL bp_hold: step %0d got %b/%h want 1/%h", k, s_v, s_addr, q[0].a);
        end
      end
      if (v && !s_stall) idx++;
      if (s_acc) begin
        n++;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bp_out: unexpected addr %h", s_addr);
        end else begin
          e = q.pop_front();
          if (s_addr !== e.a || s_last !== e.l) begin
            errors++;
            $display("FAIL bp_out: got %h/%b want %h/%b", s_addr, s_last, e.a, e.l);
          end
        end
      end
    end
    checks += 2;
    if (n != 10) begin errors++; $display("FAIL bp_count: got %0d want 10", n); end
    if (q.size() != 0) begin errors++; $display("FAIL bp_left: got %0d pending want 0", q.size()); end
  endtask

  task automatic test_wrap();
    exp_t e;
    int   n = 0;
    cfg_group_id = 2'd2;
    cfg_base_v = 1'b1; cfg_base_addr = 32'hFFFF_FFF0;
    cfg_stride_v = 1'b1; cfg_stride_loop_id = 3'd0; cfg_stride = 16'd1;
    step(1'b0, '0, 2'd0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(k == 0, pack3(16'h20, 16'h0, 16'h0), 2'd2, 1'b0, 1'b1);
      if (s_acc) begin
        n++;
        checks += 2;
        if (s_addr !== 32'h0000_0010) begin errors++; $display("FAIL wrap_const: got %h want 00000010", s_addr); end
        if (q.size() == 0) begin
          errors++; $display("FAIL wrap_out: unexpected addr %h", s_addr);
        end else begin
          e = q.pop_front();
          if (s_addr !== e.a || s_last !== e.l) begin
            errors++;
            $display("FAIL wrap_out: got %h/%b want %h/%b", s_addr, s_last, e.a, e.l);
          end
        end
      end
    end
    checks++;
    if (n != 1) begin errors++; $display("FAIL wrap_count: got %0d want 1", n); end
  endtask

  task automatic test_block_done();
    exp_t        e;
    logic [31:0] want [4];
    logic [1:0]  grp [4];
    int          n = 0;
    want[0] = 32'h1123; want[1] = 32'h8; want[2] = 32'h0; want[3] = 32'h0;
    grp[0] = 2'd0; grp[1] = 2'd0; grp[2] = 2'd1; grp[3] = 2'd2;
    block_done = 1'b1;
    cfg_group_id = 2'd0;
    cfg_stride_v = 1'b1; cfg_stride_loop_id = 3'd0; cfg_stride = 16'd8;
    for (int k = 0; k < 7; k++) begin
      if (k == 0) step(1'b1, pack3(16'd3, 16'd2, 16'd1), 2'd0, 1'b0, 1'b1);
      else if (k < 4) step(1'b1, {8{16'h0001}}, grp[k], 1'b0, 1'b1);
      else step(1'b0, '0, 2'd0, 1'b0, 1'b1);
      if (s_acc) begin
        checks += 2;
        if (n < 4 && s_addr !== want[n]) begin
          errors++; $display("FAIL bd_const: output %0d got %h want %h", n, s_addr, want[n]);
        end
        n++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bd_out: unexpected addr %h", s_addr);
        end else begin
          e = q.pop_front();
          if (s_addr !== e.a || s_last !== e.l) begin
            errors++;
            $display("FAIL bd_out: got %h/%b want %h/%b", s_addr, s_last, e.a, e.l);
          end
        end
      end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL bd_count: got %0d want 4", n); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   n = 0;
    cfg_group_id = 2'd0;
    cfg_base_v = 1'b1; cfg_base_addr = 32'h40;
    step(1'b0, '0, 2'd0, 1'b0, 1'b1);
    for (int k = 0; k < 11; k++) begin
      reset = (k == 4) ? 1'b0 : 1'b1;
      step((k < 5) || (k == 6), {$urandom, $urandom, $urandom, $urandom}, 2'd0, 1'b0, k != 4);
      if (k == 5) begin
        checks += 2;
        if (s_v !== 1'b0) begin errors++; $display("FAIL rstmid_addr_v: got %b want 0", s_v); end
        if (s_stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b want 0", s_stall); end
      end
      if (s_acc) begin
        n++;
        checks++;
        if (k >= 6) begin
          checks++;
          if (s_addr !== 32'h0) begin errors++; $display("FAIL rstmid_zero: got %h want 0", s_addr); end
        end
        if (q.size() == 0) begin
          errors++; $display("FAIL rstmid_out: unexpected addr %h", s_addr);
        end else begin
          e = q.pop_front();
          if (s_addr !== e.a || s_last !== e.l) begin
            errors++;
            $display("FAIL rstmid_out: got %h/%b want %h/%b", s_addr, s_last, e.a, e.l);
          end
        end
      end
    end
    reset = 1'b1;
    checks++;
    if (n != 3) begin errors++; $display("FAIL rstmid_count: got %0d want 3", n); end
  endtask

  task automatic test_signed();
    exp_t        e;
    logic [31:0] want;
    int          n = 0;
`ifdef LOOP_ADDR_GEN_SIGNED_STRIDE_EN
    want = 32'h0000_00F4;
`else
    want = 32'h0003_00F4;
`endif
    cfg_group_id = 2'd3;
    cfg_base_v = 1'b1; cfg_base_addr = 32'h100;
    cfg_stride_v = 1'b1; cfg_stride_loop_id = 3'd0; cfg_stride = 16'hFFFC;
    step(1'b0, '0, 2'd0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      if (k == 0) step(1'b1, pack3(16'd3, 16'd0, 16'd0), 2'd3, 1'b0, 1'b1);
      else if (k == 1) step(1'b1, pack3(16'h50, 16'd0, 16'd0), 2'd3, 1'b1, 1'b1);
      else step(1'b0, '0, 2'd0, 1'b0, 1'b1);
      if (s_acc) begin
        checks++;
        if (n == 0) begin
          checks++;
          if (s_addr !== want) begin errors++; $display("FAIL signed_const: got %h want %h", s_addr, want); end
        end
        n++;
        if (q.size() == 0) begin
          errors++; $display("FAIL signed_out: unexpected addr %h", s_addr);
        end else begin
          e = q.pop_front();
          if (s_addr !== e.a || s_last !== e.l) begin
            errors++;
            $display("FAIL signed_out: got %h/%b want %h/%b", s_addr, s_last, e.a, e.l);
          end
        end
      end
    end
    checks++;
    if (n != 2) begin errors++; $display("FAIL signed_count: got %0d want 2", n); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_group_switch();
    test_backpressure();
    test_wrap();
    test_block_done();
    test_reset_mid();
    test_signed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
